multi_flop_synchronizer: RTL and testbench

Parametrised N-stage synchroniser for a bus of independent single-bit asynchronous signals (WIDTH channels, each crossing separately; not for coherent multi-bit values). Each channel has a configurable-depth flop chain, an optional stability (glitch) filter, and registered rise/fall pulse outputs. It sits at clock-domain entry points for status lines, interrupts and slow control bits, and replaces fixed two-stage and three-stage synchronisers.

---
 rtl/multi_flop_synchronizer_pkg.sv | 19 +
 rtl/multi_flop_synchronizer_sync_filter_channel.sv | 103 ++++++++++
 rtl/multi_flop_synchronizer.sv | 54 +++++
 tb/tb_multi_flop_synchronizer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/multi_flop_synchronizer_pkg.sv
// Shared CDC helpers: constant ceil-log2 and the attribute value that tags
// synchroniser flops so place-and-route keeps them adjacent and untouched.
package multi_flop_synchronizer_pkg;

  localparam string SYNC_ATTR = "TRUE";

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Filter counter width; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (clog2(cycles + 1) < 1) ? 1 : clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/multi_flop_synchronizer_sync_filter_channel.sv
// One synchronised bit: flop chain, optional persistence filter, and
// registered rise/fall pulses derived from the next output level.
module sync_filter_channel
  import multi_flop_synchronizer_pkg::*;
#(
  parameter int STAGES        = 3,
  parameter int FILTER_CYCLES = 0,
  parameter bit RST_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  (* ASYNC_REG = SYNC_ATTR, DONT_TOUCH = SYNC_ATTR *)
  logic [1:0]        meta_q;
  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] chain_d;
  logic              sync;
  logic              out_d;
  logic              rise_q;
  logic              fall_q;

  assign chain[1:0] = meta_q;
  assign chain_d    = {chain[STAGES-2:0], in};
  assign sync       = chain[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= {2{RST_VALUE}};
    end else if (enable) begin
      meta_q <= chain_d[1:0];
    end
  end

  if (STAGES > 2) begin : g_tail
    logic [STAGES-3:0] tail_q;

    assign chain[STAGES-1:2] = tail_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        tail_q <= {(STAGES-2){RST_VALUE}};
      end else if (enable) begin
        tail_q <= chain_d[STAGES-1:2];
      end
    end
  end

  if (FILTER_CYCLES == 0) begin : g_nofilt
    assign out   = sync;
    assign out_d = chain_d[STAGES-1];
  end else begin : g_filt
    localparam int CW = cnt_width(FILTER_CYCLES);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          out_q;

    // Any cycle where sync agrees with out restarts the persistence count.
    always_comb begin
      out_d = out_q;
      cnt_d = '0;
      if (sync != out_q) begin
        if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
          out_d = sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= RST_VALUE;
        cnt_q <= '0;
      end else if (enable) begin
        out_q <= out_d;
        cnt_q <= cnt_d;
      end
    end

    assign out = out_q;
  end

  // Pulses are registered alongside the output so they align with its change.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= enable & out_d & ~out;
      fall_q <= enable & ~out_d & out;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/multi_flop_synchronizer.sv
// Bus of independent single-bit synchronisers with optional glitch filter
// and per-channel edge pulses; not for coherent multi-bit values.
module multi_flop_synchronizer
  import multi_flop_synchronizer_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int STAGES        = 3,
  parameter int FILTER_CYCLES = 0,
  parameter int RST_VALUE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam bit RST_BIT = (RST_VALUE != 0);

  if (STAGES < 2) begin : g_err_stages
    $error("multi_flop_synchronizer: STAGES must be >= 2");
  end
  if (WIDTH < 1) begin : g_err_width
    $error("multi_flop_synchronizer: WIDTH must be >= 1");
  end
  if (RST_VALUE != 0 && RST_VALUE != 1) begin : g_err_rst
    $error("multi_flop_synchronizer: RST_VALUE must be 0 or 1");
  end
  if (FILTER_CYCLES < 0) begin : g_err_filt
    $error("multi_flop_synchronizer: FILTER_CYCLES must be >= 0");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_channel #(
      .STAGES       (STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_VALUE    (RST_BIT)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .in    (in[i]),
      .out   (out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_multi_flop_synchronizer.sv
// Scoreboard bench: four synchroniser configurations share one clock;
// expectations are queued with their due cycle when stimulus is applied.
module tb_multi_flop_synchronizer;

  typedef struct {
    int         due;
    int         dut;
    string      tag;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  // a: W4 S3 F0 R0   b: W1 S2 F4 R0   c: W1 S3 F4 R0   d: W2 S3 F0 R1
  logic       rst_a, rst_b, rst_c, rst_d;
  logic       en_a, en_b, en_c, en_d;
  logic [3:0] in_a, out_a, rise_a, fall_a;
  logic       in_b, out_b, rise_b, fall_b;
  logic       in_c, out_c, rise_c, fall_c;
  logic [1:0] in_d, out_d, rise_d, fall_d;
  logic       chg_a, chg_b, chg_c, chg_d;

  multi_flop_synchronizer #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(0), .RST_VALUE(0)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));
  multi_flop_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(4), .RST_VALUE(0)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));
  multi_flop_synchronizer #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(4), .RST_VALUE(0)) dut_c (
    .clk(clk), .rst(rst_c), .enable(en_c), .in(in_c),
    .out(out_c), .rise(rise_c), .fall(fall_c), .changed(chg_c));
  multi_flop_synchronizer #(.WIDTH(2), .STAGES(3), .FILTER_CYCLES(0), .RST_VALUE(1)) dut_d (
    .clk(clk), .rst(rst_d), .enable(en_d), .in(in_d),
    .out(out_d), .rise(rise_d), .fall(fall_d), .changed(chg_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_at(input int dly, input int d, input string tag,
                        input logic [3:0] o, input logic [3:0] r,
                        input logic [3:0] f, input logic c);
    exp_t e;
    e.due = cyc + dly; e.dut = d; e.tag = tag;
    e.out = o; e.rise = r; e.fall = f; e.chg = c;
    sb.push_back(e);
  endtask

  task automatic exp_quiet(input int d0, input int d1, input int d,
                           input string tag, input logic [3:0] o);
    for (int k = d0; k <= d1; k++) exp_at(k, d, tag, o, 4'd0, 4'd0, 1'b0);
  endtask

  logic [3:0] mo, mr, mf;
  logic       mc;
  exp_t       me;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        me = sb[i];
        case (me.dut)
          0:       begin mo = out_a; mr = rise_a; mf = fall_a; mc = chg_a; end
          1:       begin mo = {3'b0, out_b}; mr = {3'b0, rise_b}; mf = {3'b0, fall_b}; mc = chg_b; end
          2:       begin mo = {3'b0, out_c}; mr = {3'b0, rise_c}; mf = {3'b0, fall_c}; mc = chg_c; end
          default: begin mo = {2'b0, out_d}; mr = {2'b0, rise_d}; mf = {2'b0, fall_d}; mc = chg_d; end
        endcase
        chk({me.tag, ".out"},  32'(mo), 32'(me.out));
        chk({me.tag, ".rise"}, 32'(mr), 32'(me.rise));
        chk({me.tag, ".fall"}, 32'(mf), 32'(me.fall));
        chk({me.tag, ".chg"},  32'(mc), 32'(me.chg));
        sb.delete(i);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1; en_d  = 1'b1;
    in_a  = 4'b0000; in_b = 1'b0; in_c = 1'b0; in_d = 2'b11;

    exp_quiet(1, 2, 0, "rst_a", 4'b0000);
    exp_quiet(1, 2, 1, "rst_b", 4'b0000);
    exp_quiet(1, 2, 2, "rst_c", 4'b0000);
    exp_quiet(1, 2, 3, "rst_d", 4'b0011);
    repeat (2) @(negedge clk);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    exp_quiet(1, 4, 0, "rel_a", 4'b0000);
    exp_quiet(1, 4, 1, "rel_b", 4'b0000);
    exp_quiet(1, 4, 2, "rel_c", 4'b0000);
    exp_quiet(1, 4, 3, "rel_d", 4'b0011);
    repeat (4) @(negedge clk);

    // 1: three-stage latency, one-cycle rise on two channels
    in_a = 4'b0101;
    exp_quiet(1, 2, 0, "t1_lat", 4'b0000);
    exp_at(3, 0, "t1_rise", 4'b0101, 4'b0101, 4'b0000, 1'b1);
    exp_quiet(4, 5, 0, "t1_after", 4'b0101);
    repeat (6) @(negedge clk);

    // 3: enable low freezes a 1 sitting in the first flop
    in_a = 4'b1101;
    exp_at(1, 0, "t3_pre", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    en_a = 1'b0;
    exp_quiet(1, 5, 0, "t3_frozen", 4'b0101);
    repeat (5) @(negedge clk);
    en_a = 1'b1;
    exp_at(1, 0, "t3_resume", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    exp_at(2, 0, "t3_rise", 4'b1101, 4'b1000, 4'b0000, 1'b1);
    exp_at(3, 0, "t3_after", 4'b1101, 4'b0000, 4'b0000, 1'b0);
    repeat (4) @(negedge clk);

    // 2: filter rejects a 3-cycle pulse, passes a held level after 2+4
    in_b = 1'b1;
    exp_quiet(1, 12, 1, "t2_glitch", 4'b0000);
    repeat (3) @(negedge clk);
    in_b = 1'b0;
    repeat (10) @(negedge clk);
    in_b = 1'b1;
    exp_quiet(1, 5, 1, "t2_wait", 4'b0000);
    exp_at(6, 1, "t2_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    exp_quiet(7, 10, 1, "t2_hold", 4'b0001);
    repeat (12) @(negedge clk);

    // 4: reset with the filter count at 3 discards everything in flight
    in_c = 1'b1;
    exp_quiet(1, 6, 2, "t4_fill", 4'b0000);
    repeat (6) @(negedge clk);
    rst_c = 1'b1;
    exp_quiet(1, 1, 2, "t4_rst", 4'b0000);
    @(negedge clk);
    rst_c = 1'b0;
    exp_quiet(1, 6, 2, "t4_refill", 4'b0000);
    exp_at(7, 2, "t4_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    exp_quiet(8, 9, 2, "t4_after", 4'b0001);
    repeat (10) @(negedge clk);

    // 5: reset-to-1 channel falls after three edges
    in_d = 2'b10;
    exp_quiet(1, 2, 3, "t5_lat", 4'b0011);
    exp_at(3, 3, "t5_fall", 4'b0010, 4'b0000, 4'b0001, 1'b1);
    exp_quiet(4, 5, 3, "t5_after", 4'b0010);
    repeat (6) @(negedge clk);

    // 6: opposite transitions on both channels at the same edge
    in_d = 2'b01;
    exp_quiet(1, 2, 3, "t6_lat", 4'b0010);
    exp_at(3, 3, "t6_both", 4'b0001, 4'b0001, 4'b0010, 1'b1);
    exp_quiet(4, 5, 3, "t6_after", 4'b0001);
    repeat (12) @(negedge clk);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
